// File: rtl/mem_resp_pkg.sv
// Shared constants and types for the memory responder: IO address map,
// RISC-V load/store funct3 codes, FSM states and the byte-lane merge helper.
package mem_resp_pkg;

    localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
    localparam logic [31:0] ADDR_LED = 32'hFFFF_FC60;
    localparam logic [31:0] ADDR_SW  = 32'hFFFF_FC70;
    localparam logic [31:0] ADDR_SEG = 32'hFFFF_FC80;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        RG_NONE = 3'd0,
        RG_RAM  = 3'd1,
        RG_LED  = 3'd2,
        RG_SW   = 3'd3,
        RG_SEG  = 3'd4
    } region_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/resp_ram.sv
// Synchronous-read word RAM with per-byte write enables; contents are not reset.
module resp_ram #(
    parameter int DEPTH = 16384,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Load/store responder: RAM plus LED/SW/SEG registers behind a valid/ready port.
// Build option MEM_RESP_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int RAM_DEPTH_WORDS = 16384,
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic [31:0]          seg_data
);

    localparam int AW = $clog2(RAM_DEPTH_WORDS);

    state_t               state_q, state_d;
    size_t                size_q, size_d, acc_size;
    region_t              region_q, region_d, acc_region;
    logic [1:0]           lo_q, lo_d, acc_lo;
    logic                 uns_q, uns_d, err_q, err_d;
    logic [31:0]          io_rdata_q, io_rdata_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          seg_q, seg_d;
    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;

    logic        accept, acc_err, store_fire;
    logic [3:0]  acc_be, ram_we;
    logic [31:0] acc_wlanes, ram_rdata, raw, shifted;

    assign accept = req_valid && (state_q == ST_IDLE);

    always_comb begin
        acc_size = SZ_W;
        if (req_we) begin
            if (req_funct3 == F3_B)      acc_size = SZ_B;
            else if (req_funct3 == F3_H) acc_size = SZ_H;
        end else begin
            if (req_funct3 == F3_B || req_funct3 == F3_BU)      acc_size = SZ_B;
            else if (req_funct3 == F3_H || req_funct3 == F3_HU) acc_size = SZ_H;
        end

        // Low address bits forced to natural alignment; the trap build rejects instead.
        case (acc_size)
            SZ_B:    acc_lo = req_addr[1:0];
            SZ_H:    acc_lo = {req_addr[1], 1'b0};
            default: acc_lo = 2'b00;
        endcase
`ifdef MEM_RESP_MISALIGN_TRAP_EN
        acc_err = ((acc_size == SZ_H) && req_addr[0]) ||
                  ((acc_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
        acc_err = 1'b0;
`endif

        case (acc_size)
            SZ_B: begin
                acc_be     = 4'b0001 << acc_lo;
                acc_wlanes = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                acc_be     = acc_lo[1] ? 4'b1100 : 4'b0011;
                acc_wlanes = {2{req_wdata[15:0]}};
            end
            default: begin
                acc_be     = 4'b1111;
                acc_wlanes = req_wdata;
            end
        endcase

        acc_region = RG_NONE;
        if ((req_addr >> (AW + 2)) == 32'd0) begin
            acc_region = RG_RAM;
        end else if (req_addr[31:8] == IO_BASE[31:8]) begin
            if (req_addr[7:2] == ADDR_LED[7:2])      acc_region = RG_LED;
            else if (req_addr[7:2] == ADDR_SW[7:2])  acc_region = RG_SW;
            else if (req_addr[7:2] == ADDR_SEG[7:2]) acc_region = RG_SEG;
        end
    end

    assign store_fire = accept && req_we && !acc_err;
    assign ram_we     = (store_fire && acc_region == RG_RAM) ? acc_be : 4'b0000;

    resp_ram #(.DEPTH(RAM_DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .re    (accept && !req_we),
        .we    (ram_we),
        .addr  (req_addr[AW+1:2]),
        .wdata (acc_wlanes),
        .rdata (ram_rdata)
    );

    assign raw     = (region_q == RG_RAM) ? ram_rdata : io_rdata_q;
    assign shifted = raw >> {lo_q, 3'b000};

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        region_d    = region_q;
        lo_d        = lo_q;
        uns_d       = uns_q;
        err_d       = err_q;
        io_rdata_d  = io_rdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        led_d       = led_q;
        seg_d       = seg_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    size_d    = acc_size;
                    region_d  = acc_region;
                    lo_d      = acc_lo;
                    uns_d     = (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
                    err_d     = acc_err;
                    rsp_err_d = acc_err;
                    case (acc_region)
                        RG_LED:  io_rdata_d = 32'(led_q);
                        RG_SW:   io_rdata_d = 32'(sw_sync_q);
                        RG_SEG:  io_rdata_d = seg_q;
                        default: io_rdata_d = 32'd0;
                    endcase
                    if (req_we) begin
                        rsp_rdata_d = 32'd0;
                        if (store_fire && acc_region == RG_LED)
                            led_d = LED_WIDTH'(merge_bytes(32'(led_q), acc_wlanes, acc_be));
                        if (store_fire && acc_region == RG_SEG)
                            seg_d = merge_bytes(seg_q, acc_wlanes, acc_be);
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                case (size_q)
                    SZ_B:    rsp_rdata_d = uns_q ? {24'd0, shifted[7:0]}
                                                 : {{24{shifted[7]}}, shifted[7:0]};
                    SZ_H:    rsp_rdata_d = uns_q ? {16'd0, shifted[15:0]}
                                                 : {{16{shifted[15]}}, shifted[15:0]};
                    default: rsp_rdata_d = raw;
                endcase
                if (err_q) rsp_rdata_d = 32'd0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_W;
            region_q    <= RG_NONE;
            lo_q        <= 2'b00;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            io_rdata_q  <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            led_q       <= '0;
            seg_q       <= 32'd0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            region_q    <= region_d;
            lo_q        <= lo_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            io_rdata_q  <= io_rdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            led_q       <= led_d;
            seg_q       <= seg_d;
            sw_meta_q   <= sw_in;
            sw_sync_q   <= sw_meta_q;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign led_out   = led_q;
    assign seg_data  = seg_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM/IO loads and stores, lane handling,
// handshake holding and reset during a pending read.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic [31:0] seg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .sw_in      (sw_in),
        .led_out    (led_out),
        .seg_data   (seg_data)
    );

    // One request from an idle responder; reports first-response latency and pulse count.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rdata, output logic err, output int pulses);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; pulses = 0; rdata = 32'hXXXX_XXXX; err = 1'bx;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                if (lat < 0) begin lat = n; rdata = rsp_rdata; err = rsp_err; end
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h want 0", led_out); end
        n_checks++; if (seg_data !== 32'h0) begin n_fail++; $display("FAIL reset_seg: got %h want 0", seg_data); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    endtask

    task automatic test_word();
        int lat, p; logic [31:0] rd; logic e;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, e, p);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sw_latency: got %0d want 1", lat); end
        n_checks++; if (p !== 1) begin n_fail++; $display("FAIL sw_pulses: got %0d want 1", p); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, e, p);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_checks++; if (p !== 1) begin n_fail++; $display("FAIL lw_pulses: got %0d want 1", p); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_half();
        int lat, p; logic [31:0] rd; logic e;
        do_req(1'b1, 3'b000, 32'h13, 32'h0000_0080, lat, rd, e, p);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h want ffffff80", rd); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", rd); end
        do_req(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'h000080AD) begin n_fail++; $display("FAIL lhu: got %h want 000080ad", rd); end
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'hFFFF80AD) begin n_fail++; $display("FAIL lh: got %h want ffff80ad", rd); end
        do_req(1'b0, 3'b000, 32'h10, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL lb_lane0: got %h want ffffffef", rd); end
    endtask

    task automatic test_misalign();
        int lat, p; logic [31:0] rd; logic e;
        logic [31:0] exp_lw12, exp_after;
        logic        exp_err;
`ifdef MEM_RESP_MISALIGN_TRAP_EN
        exp_lw12 = 32'h0; exp_err = 1'b1; exp_after = 32'h80ADBEEF;
`else
        exp_lw12 = 32'h80ADBEEF; exp_err = 1'b0; exp_after = 32'h55667788;
`endif
        do_req(1'b0, 3'b010, 32'h12, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== exp_lw12) begin n_fail++; $display("FAIL misalign_lw_rdata: got %h want %h", rd, exp_lw12); end
        n_checks++; if (e !== exp_err) begin n_fail++; $display("FAIL misalign_lw_err: got %b want %b", e, exp_err); end
        do_req(1'b1, 3'b010, 32'h11, 32'h55667788, lat, rd, e, p);
        n_checks++; if (e !== exp_err) begin n_fail++; $display("FAIL misalign_sw_err: got %b want %b", e, exp_err); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== exp_after) begin n_fail++; $display("FAIL misalign_sw_effect: got %h want %h", rd, exp_after); end
    endtask

    task automatic test_io();
        int lat, p; logic [31:0] rd; logic e;
        do_req(1'b1, 3'b010, 32'hFFFFFC60, 32'h0000_1234, lat, rd, e, p);
        n_checks++; if (led_out !== 16'h1234) begin n_fail++; $display("FAIL led_write: got %h want 1234", led_out); end
        do_req(1'b0, 3'b010, 32'hFFFFFC60, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL led_read: got %h want 00001234", rd); end
        @(negedge clk); sw_in = 16'h00A5;
        repeat (3) @(posedge clk);
        do_req(1'b0, 3'b010, 32'hFFFFFC70, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'h000000A5) begin n_fail++; $display("FAIL sw_read: got %h want 000000a5", rd); end
        do_req(1'b1, 3'b010, 32'hFFFFFC80, 32'h11223344, lat, rd, e, p);
        do_req(1'b1, 3'b000, 32'hFFFFFC82, 32'h0000_0077, lat, rd, e, p);
        n_checks++; if (seg_data !== 32'h11773344) begin n_fail++; $display("FAIL seg_byte_write: got %h want 11773344", seg_data); end
        do_req(1'b0, 3'b100, 32'hFFFFFC83, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'h00000011) begin n_fail++; $display("FAIL seg_lbu: got %h want 00000011", rd); end
    endtask

    task automatic test_unmapped();
        int lat, p; logic [31:0] rd; logic e;
        do_req(1'b1, 3'b010, 32'h0, 32'h11111111, lat, rd, e, p);
        do_req(1'b1, 3'b010, 32'h0010_0000, 32'h0000_0099, lat, rd, e, p);
        n_checks++; if (p !== 1) begin n_fail++; $display("FAIL unmapped_store_pulses: got %0d want 1", p); end
        do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_load: got %h want 0", rd); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL unmapped_err: got %b want 0", e); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL unmapped_no_alias: got %h want 11111111", rd); end
        do_req(1'b1, 3'b010, 32'h0000_FFFC, 32'hA5A5_0001, lat, rd, e, p);
        do_req(1'b0, 3'b010, 32'h0000_FFFC, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'hA5A50001) begin n_fail++; $display("FAIL ram_last_word: got %h want a5a50001", rd); end
    endtask

    task automatic test_hold();
        int n_ready, p; logic [31:0] rd;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_FFFC; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'hFFFFFC80; req_wdata = 32'h0000_CAFE;
        n_ready = -1; rd = 32'hXXXX_XXXX;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (rsp_valid) rd = rsp_rdata;
            if (req_ready) begin n_ready = n; break; end
        end
        n_checks++; if (n_ready !== 3) begin n_fail++; $display("FAIL hold_ready_cycle: got %0d want 3", n_ready); end
        n_checks++; if (rd !== 32'hA5A50001) begin n_fail++; $display("FAIL hold_load_rdata: got %h want a5a50001", rd); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (seg_data !== 32'h0000CAFE) begin n_fail++; $display("FAIL hold_store_seg: got %h want 0000cafe", seg_data); end
        p = 0;
        for (int n = 1; n <= 4; n++) begin @(negedge clk); if (rsp_valid) p++; end
        n_checks++; if (p !== 1) begin n_fail++; $display("FAIL hold_store_pulses: got %0d want 1", p); end
    endtask

    task automatic test_reset_mid();
        int lat, p; logic [31:0] rd; logic e;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_FFFC;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        p = 0;
        for (int n = 1; n <= 4; n++) begin @(negedge clk); if (rsp_valid) p++; end
        n_checks++; if (p !== 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d pulses want 0", p); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        n_checks++; if (seg_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_seg: got %h want 0", seg_data); end
        do_req(1'b0, 3'b010, 32'h0000_FFFC, 32'h0, lat, rd, e, p);
        n_checks++; if (rd !== 32'hA5A50001) begin n_fail++; $display("FAIL rstmid_ram_kept: got %h want a5a50001", rd); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; sw_in = 16'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_word();
        test_byte_half();
        test_misalign();
        test_io();
        test_unmapped();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
